model_buffer: RTL and testbench

Triangle storage for all loaded models, sitting directly upstream of the scene reader. Accepts triangle writes from the model-upload path and commits each model's triangle count on its last write. Serves (model_index, triangle_index) read requests with a registered response. Flags the final triangle of each model so the scene reader knows when to fetch the next scene instance.

---
 rtl/model_buffer.sv | 137 +++++++++++++
 tb/tb_model_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_buffer.sv
// model_buffer: triangle storage for every loaded model, upstream of the scene reader.
//
// Ports
//   clk, rst                     single clock, synchronous active-high reset
//   write_in_valid / _ready      triangle append request; ready is 1 from the first cycle after reset
//   write_in_model_index         target slot
//   write_in_data                triangle to append at the slot's open write position
//   write_in_last                closes the model: commits the number of triangles stored since the last commit
//   read_in_valid / _ready       (model_index, triangle_index) lookup
//   read_in_data                 lookup request
//   read_out_valid / _ready      registered response, one cycle after acceptance
//   read_out_data                triangle, or all zeros for a miss
//   read_out_metadata.last       final triangle of the model (always 1 for a miss)

package model_buffer_pkg;
    typedef logic [15:0] short_t;
    typedef struct packed { short_t x; short_t y; short_t z; } vertex_t;
    typedef struct packed { vertex_t v0; vertex_t v1; vertex_t v2; } triangle_t;
    typedef struct packed { short_t model_index; short_t triangle_index; } modelbuf_read_t;
    typedef struct packed { logic last; } triangle_meta_t;
endpackage

module model_buffer
    import model_buffer_pkg::*;
#(
    parameter int MAX_MODEL_COUNT    = 10,
    parameter int MAX_TRIANGLE_COUNT = 100
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           write_in_valid,
    output logic           write_in_ready,
    input  short_t         write_in_model_index,
    input  triangle_t      write_in_data,
    input  logic           write_in_last,
    input  logic           read_in_valid,
    output logic           read_in_ready,
    input  modelbuf_read_t read_in_data,
    output logic           read_out_valid,
    input  logic           read_out_ready,
    output triangle_t      read_out_data,
    output triangle_meta_t read_out_metadata
);
    localparam int     DEPTH  = MAX_MODEL_COUNT * MAX_TRIANGLE_COUNT;
    localparam int     AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int     SW     = (MAX_MODEL_COUNT > 1) ? $clog2(MAX_MODEL_COUNT) : 1;
    localparam short_t MODELS = short_t'(MAX_MODEL_COUNT);
    localparam short_t TRIS   = short_t'(MAX_TRIANGLE_COUNT);

    triangle_t mem    [DEPTH];
    short_t    wr_ptr [MAX_MODEL_COUNT];
    short_t    count  [MAX_MODEL_COUNT];
    logic      ready_q;

    // ---------------- write side ----------------
    logic          w_acc, w_slot_ok, w_store;
    logic [SW-1:0] w_slot;
    short_t        w_ptr;
    logic [AW-1:0] w_addr;

    assign write_in_ready = ready_q;
    assign w_acc     = write_in_valid && ready_q;
    assign w_slot_ok = write_in_model_index < MODELS;
    assign w_slot    = write_in_model_index[SW-1:0];
    assign w_ptr     = w_slot_ok ? wr_ptr[w_slot] : '0;
    // wr_ptr parks at TRIS once the slot is full, so further data is dropped
    // and the committed count is clamped without extra logic.
    assign w_store   = w_acc && w_slot_ok && (w_ptr < TRIS);
    assign w_addr    = AW'(int'(write_in_model_index) * MAX_TRIANGLE_COUNT + int'(w_ptr));

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            for (int i = 0; i < MAX_MODEL_COUNT; i++) begin
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            if (w_acc && w_slot_ok) begin
                if (write_in_last) begin
                    count[w_slot]  <= w_store ? w_ptr + 16'd1 : w_ptr;
                    wr_ptr[w_slot] <= '0;
                end else if (w_store) begin
                    wr_ptr[w_slot] <= w_ptr + 16'd1;
                end
            end
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_store) mem[w_addr] <= write_in_data;
    end

    // ---------------- read side ----------------
    logic          r_acc, r_slot_ok, r_hit, r_last;
    short_t        r_count;
    logic [AW-1:0] r_addr;
    triangle_t     ram_q;
    logic          valid_q, hit_q, last_q;

    assign read_in_ready = !valid_q || read_out_ready;
    assign r_acc     = read_in_valid && read_in_ready;
    assign r_slot_ok = read_in_data.model_index < MODELS;
    // count is read combinationally here, so a commit in this same cycle is not yet visible.
    assign r_count   = r_slot_ok ? count[read_in_data.model_index[SW-1:0]] : '0;
    assign r_hit     = read_in_data.triangle_index < r_count;
    assign r_last    = !r_hit || (read_in_data.triangle_index == r_count - 16'd1);
    assign r_addr    = AW'(int'(read_in_data.model_index) * MAX_TRIANGLE_COUNT
                           + int'(read_in_data.triangle_index));

    // RAM read enable is the acceptance itself, so a stalled response is never overwritten.
    // Nonblocking read alongside the write port gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (r_acc) ram_q <= mem[r_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (r_acc) begin
            valid_q <= 1'b1;
            hit_q   <= r_hit;
            last_q  <= r_last;
        end else if (read_out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Misses are zeroed after the RAM so the RAM output register needs no reset.
    assign read_out_valid         = valid_q;
    assign read_out_data          = hit_q ? ram_q : '0;
    assign read_out_metadata.last = last_q;
endmodule

// File: tb/tb_model_buffer.sv
module tb_model_buffer;
    import model_buffer_pkg::*;

    localparam int NM = 10;
    localparam int NT = 100;
    localparam int TW = $bits(triangle_t);

    logic           clk = 1'b0;
    logic           rst;
    logic           write_in_valid;
    logic           write_in_ready;
    short_t         write_in_model_index;
    triangle_t      write_in_data;
    logic           write_in_last;
    logic           read_in_valid;
    logic           read_in_ready;
    modelbuf_read_t read_in_data;
    logic           read_out_valid;
    logic           read_out_ready;
    triangle_t      read_out_data;
    triangle_meta_t read_out_metadata;

    model_buffer #(.MAX_MODEL_COUNT(NM), .MAX_TRIANGLE_COUNT(NT)) dut (
        .clk(clk), .rst(rst),
        .write_in_valid(write_in_valid), .write_in_ready(write_in_ready),
        .write_in_model_index(write_in_model_index), .write_in_data(write_in_data),
        .write_in_last(write_in_last),
        .read_in_valid(read_in_valid), .read_in_ready(read_in_ready),
        .read_in_data(read_in_data),
        .read_out_valid(read_out_valid), .read_out_ready(read_out_ready),
        .read_out_data(read_out_data), .read_out_metadata(read_out_metadata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Each slot is a triangle array, a committed length and an append position.
    typedef struct { triangle_t d; logic last; int acc; } exp_t;
    exp_t      exp_q[$];
    triangle_t m_mem [NM][NT];
    int        m_cnt [NM];
    int        m_wp  [NM];

    function automatic exp_t model_read(input short_t mi, input short_t ti);
        exp_t e;
        e.acc = 0;
        if (int'(mi) < NM && int'(ti) < m_cnt[int'(mi)]) begin
            e.d    = m_mem[int'(mi)][int'(ti)];
            e.last = (int'(ti) == m_cnt[int'(mi)] - 1);
        end else begin
            e.d    = '0;
            e.last = 1'b1;
        end
        return e;
    endfunction

    task automatic model_write(input short_t mi, input triangle_t d, input logic last);
        int s;
        s = int'(mi);
        if (s < NM) begin
            if (m_wp[s] < NT) begin
                m_mem[s][m_wp[s]] = d;
                m_wp[s]++;
            end
            if (last) begin
                m_cnt[s] = m_wp[s];
                m_wp[s]  = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_cnt[i] = 0;
            m_wp[i]  = 0;
        end
    endtask

    function automatic triangle_t rand_tri();
        logic [TW-1:0] r;
        for (int i = 0; i < TW / 16; i++) r[i*16 +: 16] = 16'($urandom());
        return triangle_t'(r);
    endfunction

    // ---------------- driver ----------------
    // One clock of stimulus. Read expectations are taken before the same-cycle write
    // is applied to the model (read-first data, pre-commit count).
    task automatic do_cycle(input logic wv, input short_t wmi, input triangle_t wd, input logic wl,
                            input logic rv, input short_t rmi, input short_t rti,
                            input logic ordy, output logic racc);
        exp_t e;
        write_in_valid       = wv;
        write_in_model_index = wmi;
        write_in_data        = wd;
        write_in_last        = wl;
        read_in_valid        = rv;
        read_in_data         = '{model_index: rmi, triangle_index: rti};
        read_out_ready       = ordy;
        @(negedge clk);
        racc = rv && read_in_ready;
        if (racc) begin
            e     = model_read(rmi, rti);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        if (wv && write_in_ready) model_write(wmi, wd, wl);
        @(posedge clk);
        #1;
        write_in_valid = 1'b0;
        read_in_valid  = 1'b0;
    endtask

    task automatic wr(input short_t mi, input triangle_t d, input logic last);
        logic a;
        do_cycle(1'b1, mi, d, last, 1'b0, '0, '0, 1'b1, a);
    endtask

    task automatic rd(input short_t mi, input short_t ti);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 50) begin
            do_cycle(1'b0, '0, '0, 1'b0, 1'b1, mi, ti, 1'b1, a);
            n++;
        end
        if (!a) chk(1'b0, "read_accept_timeout", '0, 1);
    endtask

    task automatic drain();
        logic a;
        int   n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1, a);
            n++;
        end
        chk(exp_q.size() == 0, "drain_outstanding", TW'(exp_q.size()), '0);
    endtask

    // ---------------- monitor ----------------
    logic      stall_prev = 1'b0;
    triangle_t held_d;
    logic      held_l;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (read_out_valid && stall_prev) begin
                chk(read_out_data == held_d, "hold_data", read_out_data, held_d);
                chk(read_out_metadata.last == held_l, "hold_last", TW'(read_out_metadata.last), TW'(held_l));
            end
            if (read_out_valid && !stall_prev) begin
                if (exp_q.size() == 0) chk(1'b0, "unexpected_response", read_out_data, '0);
                else chk(cyc == exp_q[0].acc + 1, "latency", TW'(cyc - exp_q[0].acc), TW'(1));
            end
            if (read_out_valid && read_out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(read_out_data == e.d, "resp_data", read_out_data, e.d);
                chk(read_out_metadata.last == e.last, "resp_last", TW'(read_out_metadata.last), TW'(e.last));
            end
            stall_prev = read_out_valid && !read_out_ready;
            held_d     = read_out_data;
            held_l     = read_out_metadata.last;
            if (stall_prev) chk(read_in_ready == 1'b0, "stall_read_in_ready", TW'(read_in_ready), '0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic      a;
        triangle_t t;
        bit        pat [8];
        int        i, n;

        rst = 1'b1;
        write_in_valid = 1'b0; write_in_model_index = '0; write_in_data = '0; write_in_last = 1'b0;
        read_in_valid = 1'b0; read_in_data = '0; read_out_ready = 1'b1;
        model_reset();

        @(posedge clk);
        @(negedge clk);
        chk(read_out_valid == 1'b0, "reset_valid", TW'(read_out_valid), '0);
        chk(read_out_data == '0, "reset_data", read_out_data, '0);
        chk(read_out_metadata.last == 1'b0, "reset_last", TW'(read_out_metadata.last), '0);
        chk(write_in_ready == 1'b0, "reset_write_ready", TW'(write_in_ready), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk(write_in_ready == 1'b1, "write_ready_after_reset", TW'(write_in_ready), TW'(1));
        @(posedge clk); #1;

        // Three triangles into model 2, read back-to-back.
        for (int k = 0; k < 3; k++) wr(16'd2, rand_tri(), k == 2);
        for (int k = 0; k < 3; k++) rd(16'd2, short_t'(k));
        drain();

        // Never-written slot and out-of-range slot.
        rd(16'd5, 16'd0);
        rd(16'd10, 16'd0);
        drain();

        // Overfill model 0: 102 writes, count clamps at 100.
        for (int k = 0; k < 102; k++) wr(16'd0, rand_tri(), k == 101);
        rd(16'd0, 16'd99);
        rd(16'd0, 16'd100);
        rd(16'd0, 16'd0);
        drain();

        // Streamed reads under back-pressure.
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        pat[4] = 1; pat[5] = 0; pat[6] = 1; pat[7] = 1;
        i = 0; n = 0;
        while (i < 6 && n < 60) begin
            do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 16'd0, short_t'(94 + i), pat[n % 8], a);
            if (a) i++;
            n++;
        end
        chk(i == 6, "stream_issued", TW'(i), TW'(6));
        drain();

        // Rewrite model 1 while reading index 3 around the commit.
        wr(16'd1, rand_tri(), 1'b0);
        wr(16'd1, rand_tri(), 1'b1);
        for (int k = 0; k < 3; k++) wr(16'd1, rand_tri(), 1'b0);
        rd(16'd1, 16'd3);
        rd(16'd1, 16'd1);
        t = rand_tri();
        do_cycle(1'b1, 16'd1, t, 1'b1, 1'b1, 16'd1, 16'd3, 1'b1, a);
        rd(16'd1, 16'd3);
        rd(16'd1, 16'd4);
        drain();

        // Same-cycle write and read of the open position of model 2 (read-first).
        do_cycle(1'b1, 16'd2, rand_tri(), 1'b0, 1'b1, 16'd2, 16'd0, 1'b1, a);
        drain();

        // Randomized mix.
        for (int k = 0; k < 600; k++) begin
            do_cycle(1'($urandom_range(0, 1)), short_t'($urandom_range(0, 11)), rand_tri(),
                     ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)), short_t'($urandom_range(0, 11)),
                     short_t'($urandom_range(0, 9)), ($urandom_range(0, 3) != 0), a);
        end
        drain();

        // Reset while a response is stalled.
        for (int k = 0; k < 3; k++) wr(16'd3, rand_tri(), k == 2);
        do_cycle(1'b0, '0, '0, 1'b0, 1'b1, 16'd3, 16'd0, 1'b0, a);
        chk(a == 1'b1, "pre_reset_accept", TW'(a), TW'(1));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk(read_out_valid == 1'b0, "valid_after_mid_reset", TW'(read_out_valid), '0);
        chk(write_in_ready == 1'b0, "write_ready_in_reset", TW'(write_in_ready), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rd(16'd3, 16'd0);
        rd(16'd0, 16'd5);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
